valve_shift_loader: RTL and testbench

//   Loads a parallel valve pattern into the board's serial valve-driver chain:

---
 rtl/valve_shift_loader.sv | 158 +++++++++++++++
 tb/tb_valve_shift_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valve_shift_loader.sv
// valve_shift_loader
// Shifts a parallel valve pattern MSB-first into the serial valve-driver chain
// on sdata/sclk. It then pulses latch_en so the driver latches update all valves
// in one step. All outputs are registered. A reset mid-load abandons the load
// before latch_en is raised, so the drivers keep their previous outputs.
module valve_shift_loader #(
    parameter int NUM_VALVES = 32,
    parameter int CLK_DIV    = 4,
    parameter int LE_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_VALVES-1:0] pattern_in,
    input  logic                  pattern_valid,
    output logic                  pattern_ready,
    output logic                  busy,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  latch_en,
    output logic                  done,
    output logic [NUM_VALVES-1:0] current_pattern
);

    localparam int BIT_W = $clog2(NUM_VALVES + 1);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int LE_W  = $clog2(LE_CYCLES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_VALVES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [LE_W-1:0]       r_le_cnt;
    // r_shadow holds the bits still to be sent after the one on sdata,
    // MSB next. r_pattern keeps the whole captured pattern for the final latch.
    logic [NUM_VALVES-1:0] r_shadow;
    logic [NUM_VALVES-1:0] r_pattern;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_sclk;
    logic                  r_sdata;
    logic                  r_latch_en;
    logic                  r_done;
    logic [NUM_VALVES-1:0] r_current;

    logic w_accept;
    logic w_bit_end;

    assign w_accept  = pattern_valid && r_ready;
    assign w_bit_end = (r_state == S_SHIFT_HI) && (r_div_cnt == DIV_LAST);

    assign pattern_ready   = r_ready;
    assign busy            = r_busy;
    assign sclk            = r_sclk;
    assign sdata           = r_sdata;
    assign latch_en        = r_latch_en;
    assign done            = r_done;
    assign current_pattern = r_current;

    // Pattern storage: capture on accept, then advance one bit at each sclk-high end.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow  <= {pattern_in[NUM_VALVES-2:0], 1'b0};
            r_pattern <= pattern_in;
        end else if (w_bit_end) begin
            r_shadow  <= {r_shadow[NUM_VALVES-2:0], 1'b0};
        end
    end

    // Load sequencer: outputs are assigned on state transitions so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            r_le_cnt   <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_sdata    <= 1'b0;
            r_latch_en <= 1'b0;
            r_done     <= 1'b0;
            r_current  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_SHIFT_LO;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_sdata   <= pattern_in[NUM_VALVES-1];
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                    end
                end
                S_SHIFT_LO: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_state   <= S_SHIFT_HI;
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b1;
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (r_div_cnt == DIV_LAST) begin
                        r_div_cnt <= '0;
                        r_sclk    <= 1'b0;
                        // sdata moves only together with the sclk fall.
                        // After the last bit the remaining shadow is zero.
                        r_sdata   <= r_shadow[NUM_VALVES-1];
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state    <= S_LATCH;
                            r_latch_en <= 1'b1;
                            r_le_cnt   <= '0;
                        end else begin
                            r_state <= S_SHIFT_LO;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                S_LATCH: begin
                    if (r_le_cnt == LE_LAST) begin
                        r_state    <= S_DONE;
                        r_latch_en <= 1'b0;
                        r_done     <= 1'b1;
                        r_current  <= r_pattern;
                    end else begin
                        r_le_cnt <= r_le_cnt + LE_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_valve_shift_loader.sv
// Testbench for valve_shift_loader.
// Instance dut: 8 valves, CLK_DIV=2, LE_CYCLES=2. It is watched every cycle by a
// reference timing model plus a pattern scoreboard.
// Instance dut_b: 32 valves, CLK_DIV=1, LE_CYCLES=1. It covers the fast-clock
// and wide-chain case.
`timescale 1ns/1ps
module tb_valve_shift_loader;

    localparam int NV        = 8;
    localparam int CD        = 2;
    localparam int LE        = 2;
    localparam int SHIFT_CYC = 2 * CD * NV;
    localparam int DONE_K    = SHIFT_CYC + LE;
    localparam int NVB       = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NV-1:0] pattern_in = '0;
    logic          pattern_valid = 1'b0;
    logic          pattern_ready, busy, sclk, sdata, latch_en, done;
    logic [NV-1:0] current_pattern;

    logic [NVB-1:0] pattern_in_b = '0;
    logic           pattern_valid_b = 1'b0;
    logic           pattern_ready_b, busy_b, sclk_b, sdata_b, latch_en_b, done_b;
    logic [NVB-1:0] current_pattern_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    valve_shift_loader #(.NUM_VALVES(NV), .CLK_DIV(CD), .LE_CYCLES(LE)) dut (
        .clk(clk), .rst(rst), .pattern_in(pattern_in), .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready), .busy(busy), .sclk(sclk), .sdata(sdata),
        .latch_en(latch_en), .done(done), .current_pattern(current_pattern)
    );

    valve_shift_loader #(.NUM_VALVES(NVB), .CLK_DIV(1), .LE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .pattern_in(pattern_in_b), .pattern_valid(pattern_valid_b),
        .pattern_ready(pattern_ready_b), .busy(busy_b), .sclk(sclk_b), .sdata(sdata_b),
        .latch_en(latch_en_b), .done(done_b), .current_pattern(current_pattern_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and scoreboard state for dut
    bit            mon_en = 1'b0;
    bit            m_active = 1'b0;
    int            m_t0 = 0;
    logic [NV-1:0] m_pat = '0;
    logic [NV-1:0] m_cur = '0;
    logic [NV-1:0] sb_q[$];
    int            acc_q[$];
    int            done_cnt = 0, rise_cnt = 0, le_cnt = 0;
    int            last_t0 = 0, last_done_cyc = 0;
    logic [NV-1:0] rbits = '0;
    logic          prev_sclk = 1'b0;
    int            k;
    logic          e_rdy, e_sclk, e_le, e_done, e_sd;

    always @(negedge clk) begin
        if (mon_en) begin
            k      = cyc - (m_t0 + 1);
            e_rdy  = !m_active;
            e_sclk = m_active && k >= 0 && k < SHIFT_CYC && (k % (2 * CD)) >= CD;
            e_le   = m_active && k >= SHIFT_CYC && k < DONE_K;
            e_done = m_active && k == DONE_K;

            n_checks++;
            if (pattern_ready !== e_rdy) begin
                n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, pattern_ready, e_rdy);
            end
            n_checks++;
            if (busy !== !e_rdy) begin
                n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, !e_rdy);
            end
            n_checks++;
            if (sclk !== e_sclk) begin
                n_fail++; $display("FAIL sclk cyc=%0d got=%b exp=%b", cyc, sclk, e_sclk);
            end
            n_checks++;
            if (latch_en !== e_le) begin
                n_fail++; $display("FAIL latch_en cyc=%0d got=%b exp=%b", cyc, latch_en, e_le);
            end
            n_checks++;
            if (done !== e_done) begin
                n_fail++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, e_done);
            end
            if (m_active && k >= 0 && k < SHIFT_CYC) begin
                e_sd = m_pat[NV - 1 - k / (2 * CD)];
                n_checks++;
                if (sdata !== e_sd) begin
                    n_fail++; $display("FAIL sdata cyc=%0d got=%b exp=%b", cyc, sdata, e_sd);
                end
            end

            if (done === 1'b1) begin
                done_cnt++;
                last_done_cyc = cyc;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_done cyc=%0d got=done exp=no_done", cyc);
                end else begin
                    m_cur = sb_q.pop_front();
                end
            end else if (!e_done) begin
                n_checks++;
                if (current_pattern !== m_cur) begin
                    n_fail++; $display("FAIL current_pattern cyc=%0d got=%h exp=%h", cyc, current_pattern, m_cur);
                end
            end

            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rise_cnt++;
                rbits = {rbits[NV-2:0], sdata};
            end
            if (latch_en === 1'b1) le_cnt++;

            if (rst) begin
                m_active = 1'b0;
                m_cur    = '0;
                sb_q.delete();
            end else if (!m_active && pattern_valid) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_pat    = pattern_in;
                last_t0  = cyc;
                acc_q.push_back(cyc);
                sb_q.push_back(pattern_in);
            end else if (m_active && k == DONE_K) begin
                m_active = 1'b0;
            end
        end
        prev_sclk = sclk;
    end

    task automatic send(input logic [NV-1:0] pat);
        int w;
        w = 0;
        @(posedge clk); #1;
        pattern_in    = pat;
        pattern_valid = 1'b1;
        @(negedge clk);
        while (pattern_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk); #1;
        pattern_valid = 1'b0;
        n_checks++;
        if (w >= 200) begin
            n_fail++; $display("FAIL send_accept got=timeout exp=accepted pat=%h", pat);
        end
    endtask

    task automatic wait_dones(input int target);
        int w;
        w = 0;
        while (done_cnt < target && w < 400) begin
            @(posedge clk);
            w++;
        end
        n_checks++;
        if (done_cnt < target) begin
            n_fail++; $display("FAIL done_wait got=%0d exp=%0d", done_cnt, target);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pattern_in = 8'h5A;       pattern_valid = 1'b1;
        pattern_in_b = 32'h1234_5678; pattern_valid_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (pattern_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%b exp=1", pattern_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
        n_checks++; if (sdata !== 1'b0) begin n_fail++; $display("FAIL rst_sdata got=%b exp=0", sdata); end
        n_checks++; if (latch_en !== 1'b0) begin n_fail++; $display("FAIL rst_latch_en got=%b exp=0", latch_en); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        n_checks++; if (current_pattern !== 8'h00) begin n_fail++; $display("FAIL rst_current got=%h exp=00", current_pattern); end
        n_checks++; if (pattern_ready_b !== 1'b1 || busy_b !== 1'b0) begin n_fail++; $display("FAIL rst_b_handshake got=%b%b exp=10", pattern_ready_b, busy_b); end
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; pattern_valid = 1'b0; pattern_valid_b = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || done_cnt != 0) begin n_fail++; $display("FAIL rst_no_accept got=busy%b/done%0d exp=busy0/done0", busy, done_cnt); end
    endtask

    task automatic test_single();
        int r0, l0, d0;
        r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
        send(8'hA5);
        wait_dones(d0 + 1);
        n_checks++; if (rise_cnt - r0 != 8) begin n_fail++; $display("FAIL a5_rises got=%0d exp=8", rise_cnt - r0); end
        n_checks++; if (rbits !== 8'hA5) begin n_fail++; $display("FAIL a5_sdata_at_rises got=%h exp=a5", rbits); end
        n_checks++; if (le_cnt - l0 != 2) begin n_fail++; $display("FAIL a5_latch_cycles got=%0d exp=2", le_cnt - l0); end
        n_checks++; if (last_done_cyc - last_t0 != 35) begin n_fail++; $display("FAIL a5_done_latency got=%0d exp=35", last_done_cyc - last_t0); end
        n_checks++; if (current_pattern !== 8'hA5) begin n_fail++; $display("FAIL a5_current got=%h exp=a5", current_pattern); end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL a5_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        int r0, l0, d0, gap;
        r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
        send(8'hA5);
        send(8'h3C);
        wait_dones(d0 + 2);
        gap = (acc_q.size() >= 2) ? acc_q[acc_q.size() - 1] - acc_q[acc_q.size() - 2] : -1;
        n_checks++; if (gap != 36) begin n_fail++; $display("FAIL b2b_accept_gap got=%0d exp=36", gap); end
        n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
        n_checks++; if (rise_cnt - r0 != 16) begin n_fail++; $display("FAIL b2b_rises got=%0d exp=16", rise_cnt - r0); end
        n_checks++; if (le_cnt - l0 != 4) begin n_fail++; $display("FAIL b2b_latch_cycles got=%0d exp=4", le_cnt - l0); end
        n_checks++; if (current_pattern !== 8'h3C) begin n_fail++; $display("FAIL b2b_current got=%h exp=3c", current_pattern); end
    endtask

    task automatic test_reset_mid();
        int r0, l0, d0, w;
        r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt; w = 0;
        send(8'hFF);
        while (rise_cnt - r0 < 3 && w < 100) begin
            @(posedge clk);
            w++;
        end
        n_checks++; if (rise_cnt - r0 != 3) begin n_fail++; $display("FAIL mid_third_rise got=%0d exp=3", rise_cnt - r0); end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("FAIL mid_sclk got=%b exp=0", sclk); end
        n_checks++; if (latch_en !== 1'b0) begin n_fail++; $display("FAIL mid_latch_en got=%b exp=0", latch_en); end
        n_checks++; if (pattern_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got=%b exp=1", pattern_ready); end
        n_checks++; if (current_pattern !== 8'h00) begin n_fail++; $display("FAIL mid_current got=%h exp=00", current_pattern); end
        repeat (60) @(posedge clk);
        @(negedge clk);
        n_checks++; if (done_cnt != d0) begin n_fail++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, d0); end
        n_checks++; if (le_cnt != l0) begin n_fail++; $display("FAIL mid_no_latch got=%0d exp=%0d", le_cnt, l0); end
    endtask

    task automatic test_patterns();
        int r0, l0, d0;
        r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
        send(8'h00);
        wait_dones(d0 + 1);
        n_checks++; if (rbits !== 8'h00 || rise_cnt - r0 != 8) begin n_fail++; $display("FAIL p00_bits got=%h/%0d exp=00/8", rbits, rise_cnt - r0); end
        n_checks++; if (le_cnt - l0 != 2) begin n_fail++; $display("FAIL p00_latch got=%0d exp=2", le_cnt - l0); end
        n_checks++; if (current_pattern !== 8'h00) begin n_fail++; $display("FAIL p00_current got=%h exp=00", current_pattern); end
        r0 = rise_cnt; l0 = le_cnt; d0 = done_cnt;
        send(8'hFF);
        wait_dones(d0 + 1);
        n_checks++; if (rbits !== 8'hFF) begin n_fail++; $display("FAIL pff_bits got=%h exp=ff", rbits); end
        send(8'hFF);
        wait_dones(d0 + 2);
        n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL pff_twice_dones got=%0d exp=2", done_cnt - d0); end
        n_checks++; if (rise_cnt - r0 != 16) begin n_fail++; $display("FAIL pff_twice_rises got=%0d exp=16", rise_cnt - r0); end
        n_checks++; if (le_cnt - l0 != 4) begin n_fail++; $display("FAIL pff_twice_latch got=%0d exp=4", le_cnt - l0); end
        n_checks++; if (current_pattern !== 8'hFF) begin n_fail++; $display("FAIL pff_current got=%h exp=ff", current_pattern); end
    endtask

    task automatic test_wide();
        int   lc, t0, nr, prev_rise, done_at, le_n;
        bit   acc;
        logic pb, exp_sd;
        lc = 0; t0 = -1000; nr = 0; prev_rise = -1; done_at = -1; le_n = 0;
        acc = 1'b0; pb = 1'b0;
        @(posedge clk); #1;
        pattern_in_b    = 32'h8000_0001;
        pattern_valid_b = 1'b1;
        while (done_at < 0 && lc < 200) begin
            @(negedge clk);
            if (!acc && pattern_ready_b === 1'b1) begin
                acc = 1'b1;
                t0  = lc;
            end
            if (sclk_b === 1'b1 && pb === 1'b0) begin
                exp_sd = (nr == 0 || nr == 31);
                n_checks++;
                if (sdata_b !== exp_sd) begin n_fail++; $display("FAIL wide_sdata rise=%0d got=%b exp=%b", nr, sdata_b, exp_sd); end
                if (prev_rise >= 0) begin
                    n_checks++;
                    if (lc - prev_rise != 2) begin n_fail++; $display("FAIL wide_period rise=%0d got=%0d exp=2", nr, lc - prev_rise); end
                end
                prev_rise = lc;
                nr++;
            end
            pb = sclk_b;
            if (latch_en_b === 1'b1) le_n++;
            if (done_b === 1'b1) done_at = lc;
            lc++;
            @(posedge clk); #1;
            if (acc) pattern_valid_b = 1'b0;
        end
        n_checks++; if (nr != 32) begin n_fail++; $display("FAIL wide_rises got=%0d exp=32", nr); end
        n_checks++; if (le_n != 1) begin n_fail++; $display("FAIL wide_latch got=%0d exp=1", le_n); end
        n_checks++; if (done_at - t0 != 66) begin n_fail++; $display("FAIL wide_done_latency got=%0d exp=66", done_at - t0); end
        @(negedge clk);
        n_checks++; if (current_pattern_b !== 32'h8000_0001) begin n_fail++; $display("FAIL wide_current got=%h exp=80000001", current_pattern_b); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL wide_busy_after got=%b exp=0", busy_b); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_patterns();
        test_wide();
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
